hazard_scoreboard: RTL and testbench

// Hazard and forwarding controller for the 5-stage MIPS pipeline; the producer side of the Execute stage's

---
 rtl/hazard_scoreboard_if.sv | 31 +++
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 tb/tb_hazard_scoreboard.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// D-stage request and hazard-control response bundle between the decode stage and the scoreboard.
// master drives the decode-stage instruction fields; slave returns stall, forward selects and the stall count.
interface hazard_scoreboard_if #(
    parameter int TW    = 2,
    parameter int CNT_W = 32
);
    logic [4:0]       rs_d;
    logic [4:0]       rt_d;
    logic [TW-1:0]    tuse_rs_d;
    logic [TW-1:0]    tuse_rt_d;
    logic [4:0]       dst_d;
    logic             regwrite_d;
    logic [TW-1:0]    tnew_d;
    logic             flush_e;
    logic             stall;
    logic [1:0]       fwd_rs_d;
    logic [1:0]       fwd_rt_d;
    logic [1:0]       fwd_a_e;
    logic [1:0]       fwd_b_e;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, regwrite_d, tnew_d, flush_e,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_a_e, fwd_b_e, stall_count
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, regwrite_d, tnew_d, flush_e,
        output stall, fwd_rs_d, fwd_rt_d, fwd_a_e, fwd_b_e, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: 3-slot (E, M, W) writer scoreboard with Tnew countdown driving stall and forward selects.
// Scoreboard advances one slot per clk; all outputs are combinational from current slots and D inputs, forced to 0 in reset.
module hazard_scoreboard #(
    parameter int TW    = 2,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave hz
);
    typedef struct packed {
        logic          vld;
        logic          we;
        logic [4:0]    dst;
        logic [TW-1:0] tnew;
    } slot_t;

    slot_t            e_slot_q, e_slot_d;
    slot_t            m_slot_q, m_slot_d;
    slot_t            w_slot_q, w_slot_d;
    logic [4:0]       e_rs_q, e_rs_d;
    logic [4:0]       e_rt_q, e_rt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             stall_raw;
    logic [1:0]       fwd_rs_raw;
    logic [1:0]       fwd_rt_raw;
    logic [1:0]       fwd_a_raw;
    logic [1:0]       fwd_b_raw;

    function automatic logic hit(input slot_t s, input logic [4:0] r);
        return s.vld && s.we && (s.dst == r) && (r != 5'd0);
    endfunction

    function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // A result is forwardable from M only once its Tnew there has reached 0,
    // so a consumer must wait while the remaining Tnew exceeds its Tuse.
    function automatic logic src_stall(input logic [4:0] r, input logic [TW-1:0] tuse);
        return (hit(e_slot_q, r) && (e_slot_q.tnew > tuse)) ||
               (hit(m_slot_q, r) && (m_slot_q.tnew > tuse));
    endfunction

    // M holds the younger value, so it wins over W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r);
        if (hit(m_slot_q, r)) begin
            return 2'b10;
        end else if (hit(w_slot_q, r)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        stall_raw  = src_stall(hz.rs_d, hz.tuse_rs_d) || src_stall(hz.rt_d, hz.tuse_rt_d);
        fwd_rs_raw = fwd_sel(hz.rs_d);
        fwd_rt_raw = fwd_sel(hz.rt_d);
        fwd_a_raw  = e_slot_q.vld ? fwd_sel(e_rs_q) : 2'b00;
        fwd_b_raw  = e_slot_q.vld ? fwd_sel(e_rt_q) : 2'b00;
    end

    assign hz.stall       = stall_raw & ~reset;
    assign hz.fwd_rs_d    = reset ? 2'b00 : fwd_rs_raw;
    assign hz.fwd_rt_d    = reset ? 2'b00 : fwd_rt_raw;
    assign hz.fwd_a_e     = reset ? 2'b00 : fwd_a_raw;
    assign hz.fwd_b_e     = reset ? 2'b00 : fwd_b_raw;
    assign hz.stall_count = reset ? '0 : cnt_q;

    always_comb begin
        w_slot_d      = m_slot_q;
        w_slot_d.tnew = dec_sat(m_slot_q.tnew);
        m_slot_d      = e_slot_q;
        m_slot_d.tnew = dec_sat(e_slot_q.tnew);
        e_slot_d      = '0;
        e_rs_d        = 5'd0;
        e_rt_d        = 5'd0;
        // A stall and a flush in the same cycle still yield exactly one bubble.
        if (!(stall_raw || hz.flush_e)) begin
            e_slot_d.vld  = 1'b1;
            e_slot_d.we   = hz.regwrite_d;
            e_slot_d.dst  = hz.dst_d;
            e_slot_d.tnew = hz.tnew_d;
            e_rs_d        = hz.rs_d;
            e_rt_d        = hz.rt_d;
        end
        cnt_d = cnt_q + (stall_raw ? CNT_W'(1) : CNT_W'(0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_slot_q <= '0;
            m_slot_q <= '0;
            w_slot_q <= '0;
            e_rs_q   <= 5'd0;
            e_rt_q   <= 5'd0;
            cnt_q    <= '0;
        end else begin
            e_slot_q <= e_slot_d;
            m_slot_q <= m_slot_d;
            w_slot_q <= w_slot_d;
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            cnt_q    <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    // A load still in flight in M can never feed the instruction in E directly.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(e_slot_q.vld && hit(m_slot_q, e_rs_q) && (m_slot_q.tnew != '0)));
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios then random traffic, scored against an age-based model.
// Expected outputs are queued per cycle by the stimulus and popped/compared by an independent monitor.
module tb_hazard_scoreboard;
    logic clk;
    logic reset;

    hazard_scoreboard_if #(.TW(2), .CNT_W(32)) hz ();

    hazard_scoreboard #(.TW(2), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit vld;
        bit we;
        int dst;
        int tnew;
        int rs;
        int rt;
    } ent_t;

    typedef struct {
        int stall;
        int frs;
        int frt;
        int fa;
        int fb;
        int cnt;
    } exp_t;

    ent_t pipe[$];   // index = age in cycles since entering E: 0=E, 1=M, 2=W
    exp_t expq[$];
    int   mcnt;
    int   tests;
    int   fails;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycles still missing before the writer's value exists, given its age.
    function automatic int remaining(input int age);
        int r;
        r = pipe[age].tnew - age;
        return (r < 0) ? 0 : r;
    endfunction

    function automatic bit m_hit(input int age, input int r);
        return pipe[age].vld && pipe[age].we && (pipe[age].dst == r) && (r != 0);
    endfunction

    function automatic bit needs_wait(input int r, input int tuse);
        return (m_hit(0, r) && remaining(0) > tuse) || (m_hit(1, r) && remaining(1) > tuse);
    endfunction

    // Newest in-flight writer already past E supplies the value.
    function automatic int src_sel(input int r);
        if (m_hit(1, r)) return 2;
        if (m_hit(2, r)) return 1;
        return 0;
    endfunction

    function automatic ent_t bubble();
        ent_t b;
        b = '{vld: 1'b0, we: 1'b0, dst: 0, tnew: 0, rs: 0, rt: 0};
        return b;
    endfunction

    task automatic cyc(input int rs, input int rt, input int tus, input int tut,
                       input int dst, input int we, input int tnew, input int fl, input int rst);
        exp_t e;
        ent_t n;
        @(posedge clk);
        #1;
        reset         = rst[0];
        hz.rs_d       = rs[4:0];
        hz.rt_d       = rt[4:0];
        hz.tuse_rs_d  = tus[1:0];
        hz.tuse_rt_d  = tut[1:0];
        hz.dst_d      = dst[4:0];
        hz.regwrite_d = we[0];
        hz.tnew_d     = tnew[1:0];
        hz.flush_e    = fl[0];
        if (rst != 0) begin
            e = '{stall: 0, frs: 0, frt: 0, fa: 0, fb: 0, cnt: 0};
            expq.push_back(e);
            pipe = '{bubble(), bubble(), bubble()};
            mcnt = 0;
        end else begin
            e.stall = int'(needs_wait(rs, tus) || needs_wait(rt, tut));
            e.frs   = src_sel(rs);
            e.frt   = src_sel(rt);
            e.fa    = pipe[0].vld ? src_sel(pipe[0].rs) : 0;
            e.fb    = pipe[0].vld ? src_sel(pipe[0].rt) : 0;
            e.cnt   = mcnt;
            expq.push_back(e);
            mcnt += e.stall;
            if (e.stall != 0 || fl != 0) begin
                n = bubble();
            end else begin
                n = '{vld: 1'b1, we: (we != 0), dst: dst, tnew: tnew, rs: rs, rt: rt};
            end
            pipe.push_front(n);
            void'(pipe.pop_back());
        end
    endtask

    task automatic nop();
        cyc(0, 0, 3, 3, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 3, 3, 0, 0, 0, 0, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("stall",       int'(hz.stall),       e.stall);
            chk("fwd_rs_d",    int'(hz.fwd_rs_d),    e.frs);
            chk("fwd_rt_d",    int'(hz.fwd_rt_d),    e.frt);
            chk("fwd_a_e",     int'(hz.fwd_a_e),     e.fa);
            chk("fwd_b_e",     int'(hz.fwd_b_e),     e.fb);
            chk("stall_count", int'(hz.stall_count), e.cnt);
        end
    end

    initial begin
        int rs, rt, tus, tut;
        tests = 0;
        fails = 0;
        mcnt  = 0;
        pipe  = '{bubble(), bubble(), bubble()};
        reset = 1'b1;
        hz.rs_d = '0; hz.rt_d = '0; hz.tuse_rs_d = 2'd3; hz.tuse_rt_d = 2'd3;
        hz.dst_d = '0; hz.regwrite_d = 1'b0; hz.tnew_d = '0; hz.flush_e = 1'b0;

        do_reset();
        #2 chk("rst_stall", int'(hz.stall), 0);
        chk("rst_cnt", int'(hz.stall_count), 0);

        // T1: addu $1,$2,$3 ; addu $4,$1,$5
        do_reset();
        cyc(2, 3, 1, 1, 1, 1, 1, 0, 0);
        #2 chk("t1_stall_a", int'(hz.stall), 0);
        cyc(1, 5, 1, 1, 4, 1, 1, 0, 0);
        #2 chk("t1_stall_b", int'(hz.stall), 0);
        nop();
        #2 chk("t1_fwd_a", int'(hz.fwd_a_e), 2);

        // T2: lw $3 ; addu $6,$3,$3
        do_reset();
        cyc(0, 0, 1, 3, 3, 1, 2, 0, 0);
        cyc(3, 3, 1, 1, 6, 1, 1, 0, 0);
        #2 chk("t2_stall_1", int'(hz.stall), 1);
        cyc(3, 3, 1, 1, 6, 1, 1, 0, 0);
        #2 chk("t2_stall_2", int'(hz.stall), 0);
        nop();
        #2 chk("t2_fwd_a", int'(hz.fwd_a_e), 1);
        chk("t2_fwd_b", int'(hz.fwd_b_e), 1);
        chk("t2_cnt", int'(hz.stall_count), 1);

        // T3: addu $7 ; beq $7,$0
        do_reset();
        cyc(1, 2, 1, 1, 7, 1, 1, 0, 0);
        cyc(7, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t3_stall", int'(hz.stall), 1);
        cyc(7, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t3_stall_end", int'(hz.stall), 0);
        chk("t3_fwd_rs", int'(hz.fwd_rs_d), 2);

        // T3 variant: lw $7 ; beq $7,$0 stalls twice
        do_reset();
        cyc(0, 0, 1, 3, 7, 1, 2, 0, 0);
        cyc(7, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t3v_stall_1", int'(hz.stall), 1);
        cyc(7, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t3v_stall_2", int'(hz.stall), 1);
        cyc(7, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("t3v_stall_3", int'(hz.stall), 0);
        chk("t3v_fwd_rs", int'(hz.fwd_rs_d), 1);

        // T4: writer to $0 then reader of $0
        do_reset();
        cyc(1, 1, 1, 1, 0, 1, 2, 0, 0);
        cyc(0, 0, 0, 0, 8, 1, 1, 0, 0);
        #2 chk("t4_stall", int'(hz.stall), 0);
        chk("t4_fwd_rs", int'(hz.fwd_rs_d), 0);
        nop();
        #2 chk("t4_fwd_a", int'(hz.fwd_a_e), 0);

        // T5: reset during a load-use stall
        do_reset();
        cyc(0, 0, 1, 3, 3, 1, 2, 0, 0);
        cyc(3, 3, 1, 1, 6, 1, 1, 0, 0);
        #2 chk("t5_pre_stall", int'(hz.stall), 1);
        cyc(3, 3, 1, 1, 6, 1, 1, 0, 1);
        cyc(3, 3, 1, 1, 6, 1, 1, 0, 0);
        #2 chk("t5_stall", int'(hz.stall), 0);
        chk("t5_cnt", int'(hz.stall_count), 0);
        chk("t5_fwd_rs", int'(hz.fwd_rs_d), 0);

        // T6: stall and flush together, then the dependent reader
        do_reset();
        cyc(0, 0, 1, 3, 3, 1, 2, 0, 0);
        cyc(3, 3, 1, 1, 6, 1, 1, 1, 0);
        #2 chk("t6_stall", int'(hz.stall), 1);
        cyc(3, 3, 1, 1, 6, 1, 1, 0, 0);
        #2 chk("t6_bubble_fwd_a", int'(hz.fwd_a_e), 0);
        chk("t6_cnt", int'(hz.stall_count), 1);
        nop();
        #2 chk("t6_fwd_a", int'(hz.fwd_a_e), 1);

        // Random traffic over a small register window so hazards are frequent.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rs  = $urandom_range(0, 7);
            rt  = $urandom_range(0, 7);
            tus = $urandom_range(0, 2);
            if (tus == 2) begin
                tus = 3;
                rs  = 0;
            end
            tut = $urandom_range(0, 3);
            cyc(rs, rt, tus, tut, $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 2), ($urandom_range(0, 7) == 0) ? 1 : 0,
                ($urandom_range(0, 59) == 0) ? 1 : 0);
        end
        nop();

        for (int k = 0; k < 10 && expq.size() > 0; k++) @(posedge clk);
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, required 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
